regfile_dump_reader: RTL and testbench

Sequential read-out engine for the ID-stage register file in the no-pipeline core. On a start request it walks every architectural register from index 0 to NREGS-1 through one read port and streams each (index, value) pair out over a valid/ready interface. Used for debug dumps, trace capture and end-of-test register comparison. It is the read-side counterpart to the register file's write path.

---
 rtl/regfile_dump_reader_pkg.sv | 15 +
 rtl/regfile_dump_reader_if.sv | 31 +++
 rtl/regfile_dump_reader_stream_out_reg.sv | 40 ++++
 rtl/regfile_dump_reader.sv | 101 ++++++++++
 tb/tb_regfile_dump_reader.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM state encoding
// and the default register-file geometry used by the core's register file.
package regfile_dump_reader_pkg;

   localparam int DEF_XLEN   = 32;
   localparam int DEF_NREGS  = 32;
   localparam int DEF_ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready stream carrying (index, value) beats out of the dump reader.
interface regfile_dump_reader_if
   import regfile_dump_reader_pkg::*;
#(
   parameter int XLEN   = DEF_XLEN,
   parameter int ADDR_W = DEF_ADDR_W
);

   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_index;
   logic [XLEN-1:0]   out_data;
   logic              out_last;

   modport master (
      output out_valid,
      output out_index,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_index,
      input  out_data,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/regfile_dump_reader_stream_out_reg.sv
// Single-entry valid/ready output slice. When load is high the slice takes a
// new beat (or empties when in_valid is low); flush empties it regardless.
module stream_out_reg
   import regfile_dump_reader_pkg::*;
#(
   parameter int XLEN   = DEF_XLEN,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_index,
   input  logic [XLEN-1:0]   in_data,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_index,
   output logic [XLEN-1:0]   out_data
);

   // Beat register: flush drops the beat, load replaces it, otherwise hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: index/data are reset too, not only valid, so the whole bus reads zero out of reset.
         out_valid <= 1'b0;
         out_index <= '0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         // NOTE: non-blocking assignments keep every register here reading pre-edge values.
         out_valid <= in_valid;
         if (in_valid) begin
            out_index <= in_index;
            out_data  <= in_data;
         end
      end
   end

endmodule

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: on start, walks indices 0..NREGS-1 through a
// single combinational read port and streams (index, value) beats out over a
// valid/ready interface. Each value is captured at the edge that loads it.
module regfile_dump_reader
   import regfile_dump_reader_pkg::*;
#(
   parameter int XLEN   = DEF_XLEN,
   parameter int NREGS  = DEF_NREGS,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     rf_raddr,
   input  logic [XLEN-1:0]       rf_rdata,
   regfile_dump_reader_if.master bus
);

   localparam int                PTR_W    = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

   state_t           state;
   logic [PTR_W-1:0] rd_ptr;
   logic             load;
   logic             in_range;
   logic             slice_load;
   logic             slice_flush;

   // NREGS is a power of two, so rd_ptr < NREGS is simply the top bit clear.
   assign in_range    = !rd_ptr[ADDR_W];
   assign rf_raddr    = rd_ptr[ADDR_W-1:0];
   assign load        = !bus.out_valid || bus.out_ready;
   assign slice_flush = (state == RUN) && abort;
   assign slice_load  = (state == RUN) && !abort && load;
   assign bus.out_last = bus.out_valid && (bus.out_index == LAST_IDX);

   stream_out_reg #(
      .XLEN   (XLEN),
      .ADDR_W (ADDR_W)
   ) u_out (
      .clk       (clk),
      .reset     (reset),
      .load      (slice_load),
      .flush     (slice_flush),
      .in_valid  (in_range),
      .in_index  (rd_ptr[ADDR_W-1:0]),
      .in_data   (rf_rdata),
      .out_valid (bus.out_valid),
      .out_index (bus.out_index),
      .out_data  (bus.out_data)
   );

   // Dump sequencer: state, read pointer and the registered busy/done flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         rd_ptr <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               rd_ptr <= '0;
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (abort) begin
                  state  <= IDLE;
                  rd_ptr <= '0;
                  busy   <= 1'b0;
               end else if (load) begin
                  if (in_range) begin
                     rd_ptr <= rd_ptr + PTR_W'(1);
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               rd_ptr <= '0;
               busy   <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               rd_ptr <= '0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a timing table for the plain
// dump, a beat scoreboard for every dump, and hand-written corner sequences.
module tb_regfile_dump_reader;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
   } beat_t;

   typedef struct {
      int         cyc;
      logic       busy;
      logic       valid;
      logic       last;
      logic       done;
      logic [4:0] idx;
      logic [4:0] raddr;
   } vec_t;

   typedef struct {
      int          cyc;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic [4:0]  rf_raddr;
   logic [31:0] rf_rdata;

   logic        rf_init;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] rf [32];

   regfile_dump_reader_if #(.XLEN(32), .ADDR_W(5)) bus ();

   regfile_dump_reader dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .rf_raddr (rf_raddr),
      .rf_rdata (rf_rdata),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Register file model: combinational read, write commits at the clock edge.
   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'h1000_0000 + 32'(i);
      end else if (wr_en) begin
         rf[wr_addr] <= wr_data;
      end
   end
   assign rf_rdata = rf[rf_raddr];

   int          n_checks = 0;
   int          n_pass   = 0;
   int          done_cnt = 0;
   beat_t       sb[$];
   wr_t         wsched[$];
   logic [31:0] exp_rf [32];
   vec_t        vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   // Scoreboard: every accepted beat must match the next expected beat.
   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL sb_extra_beat: got index %0d, want no beat", bus.out_index);
         end else begin
            beat_t e;
            e = sb.pop_front();
            check("beat_index", 64'(bus.out_index), 64'(e.idx));
            check("beat_data",  64'(bus.out_data),  64'(e.data));
            check("beat_last",  64'(bus.out_last),  64'(e.idx == 5'd31));
         end
      end
   end

   // Stall stability: a beat held against out_ready=0 must not change.
   logic        prev_stall = 1'b0;
   logic [4:0]  prev_idx;
   logic [31:0] prev_data;
   always @(negedge clk) begin
      if (!reset && prev_stall) begin
         check("stall_valid", 64'(bus.out_valid), 64'(1));
         check("stall_index", 64'(bus.out_index), 64'(prev_idx));
         check("stall_data",  64'(bus.out_data),  64'(prev_data));
      end
      prev_stall = !reset && bus.out_valid && !bus.out_ready && !abort;
      prev_idx   = bus.out_index;
      prev_data  = bus.out_data;
      if (!reset && done) done_cnt++;
   end

   task automatic push_dump(input int n);
      for (int i = 0; i < n; i++) sb.push_back('{idx: 5'(i), data: exp_rf[i]});
   endtask

   task automatic apply_writes(input int c);
      wr_en = 1'b0;
      foreach (wsched[k]) begin
         if (wsched[k].cyc == c) begin
            wr_en   = 1'b1;
            wr_addr = wsched[k].addr;
            wr_data = wsched[k].data;
         end
      end
   endtask

   // One dump from a start pulse in cycle 0; reports the done cycle and stalls.
   task automatic run_full(input bit toggle, output int done_cyc, output int stalls);
      stalls   = 0;
      done_cyc = -1;
      @(posedge clk); #1;
      start = 1'b1;
      bus.out_ready = 1'b1;
      apply_writes(0);
      for (int c = 1; c < 200 && done_cyc < 0; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         bus.out_ready = toggle ? (c % 2 == 0) : 1'b1;
         apply_writes(c);
         @(negedge clk);
         if (bus.out_valid && !bus.out_ready) stalls++;
         if (done) done_cyc = c;
      end
      wr_en = 1'b0;
      bus.out_ready = 1'b1;
      check("dump_finished", 64'(done_cyc >= 0), 64'(1));
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_after_done", 64'(busy), 64'(0));
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
      end
   endtask

   initial begin
      int dc, st, dcnt0, k;
      int done_a, done_b;

      vecs[0] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0};
      vecs[1] = '{2,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  5'd1};
      vecs[2] = '{3,  1'b1, 1'b1, 1'b0, 1'b0, 5'd1,  5'd2};
      vecs[3] = '{17, 1'b1, 1'b1, 1'b0, 1'b0, 5'd15, 5'd16};
      vecs[4] = '{32, 1'b1, 1'b1, 1'b0, 1'b0, 5'd30, 5'd31};
      vecs[5] = '{33, 1'b1, 1'b1, 1'b1, 1'b0, 5'd31, 5'd0};
      vecs[6] = '{34, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0};
      vecs[7] = '{35, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0};
      for (int i = 0; i < 32; i++) exp_rf[i] = 32'h1000_0000 + 32'(i);

      reset = 1'b1; rf_init = 1'b1; start = 1'b0; abort = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0; rf_init = 1'b0;
      @(negedge clk);

      // Reset state.
      check("rst_busy",  64'(busy), 64'(0));
      check("rst_done",  64'(done), 64'(0));
      check("rst_valid", 64'(bus.out_valid), 64'(0));
      check("rst_index", 64'(bus.out_index), 64'(0));
      check("rst_data",  64'(bus.out_data),  64'(0));
      check("rst_raddr", 64'(rf_raddr), 64'(0));
      check("rst_last",  64'(bus.out_last),  64'(0));

      // Plain dump, out_ready held high, timing checked against the table.
      push_dump(32);
      dcnt0 = done_cnt;
      k = 0;
      @(posedge clk); #1;
      start = 1'b1;
      for (int c = 1; c <= 36; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         if (k < 8 && vecs[k].cyc == c) begin
            check($sformatf("c%0d_busy", c),  64'(busy), 64'(vecs[k].busy));
            check($sformatf("c%0d_valid", c), 64'(bus.out_valid), 64'(vecs[k].valid));
            check($sformatf("c%0d_last", c),  64'(bus.out_last),  64'(vecs[k].last));
            check($sformatf("c%0d_done", c),  64'(done), 64'(vecs[k].done));
            check($sformatf("c%0d_raddr", c), 64'(rf_raddr), 64'(vecs[k].raddr));
            if (vecs[k].valid)
               check($sformatf("c%0d_index", c), 64'(bus.out_index), 64'(vecs[k].idx));
            k++;
         end
      end
      check("plain_done_count", 64'(done_cnt - dcnt0), 64'(1));
      check("plain_sb_empty",   64'(sb.size()), 64'(0));

      // out_ready toggling: every stall cycle delays done by one.
      push_dump(32);
      dcnt0 = done_cnt;
      run_full(1'b1, dc, st);
      check("toggle_done_cycle", 64'(dc), 64'(34 + st));
      check("toggle_stalled",    64'(st > 0), 64'(1));
      check("toggle_done_count", 64'(done_cnt - dcnt0), 64'(1));
      check("toggle_sb_empty",   64'(sb.size()), 64'(0));

      // Abort while index 10 is valid and not accepted.
      push_dump(10);
      dcnt0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1;
      bus.out_ready = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (c == 12) begin
            bus.out_ready = 1'b0;
            abort = 1'b1;
         end
         @(negedge clk);
      end
      check("abort_pre_valid", 64'(bus.out_valid), 64'(1));
      check("abort_pre_index", 64'(bus.out_index), 64'(10));
      @(posedge clk); #1;
      abort = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("abort_valid", 64'(bus.out_valid), 64'(0));
      check("abort_busy",  64'(busy), 64'(0));
      idle_cycles(3);
      check("abort_no_done",  64'(done_cnt - dcnt0), 64'(0));
      check("abort_sb_empty", 64'(sb.size()), 64'(0));
      push_dump(32);
      run_full(1'b0, dc, st);
      check("restart_done_cycle", 64'(dc), 64'(34));
      check("restart_sb_empty",   64'(sb.size()), 64'(0));

      // Snapshot: write to index 5 at its sampling edge, write ahead to index 20.
      for (int i = 0; i < 32; i++)
         sb.push_back('{idx: 5'(i), data: (i == 20) ? 32'hCAFE_F00D : exp_rf[i]});
      wsched.push_back('{cyc: 6, addr: 5'd5,  data: 32'hDEAD_BEEF});
      wsched.push_back('{cyc: 7, addr: 5'd20, data: 32'hCAFE_F00D});
      run_full(1'b0, dc, st);
      wsched.delete();
      exp_rf[5]  = 32'hDEAD_BEEF;
      exp_rf[20] = 32'hCAFE_F00D;
      check("snap_done_cycle", 64'(dc), 64'(34));
      check("snap_sb_empty",   64'(sb.size()), 64'(0));

      // start held high: one dump per IDLE entry, back-to-back.
      push_dump(32);
      push_dump(32);
      dcnt0 = done_cnt;
      done_a = -1;
      done_b = -1;
      @(posedge clk); #1;
      start = 1'b1;
      for (int c = 1; c <= 76; c++) begin
         @(posedge clk); #1;
         if (c == 69) start = 1'b0;
         @(negedge clk);
         if (done && done_a < 0) done_a = c;
         else if (done && done_b < 0) done_b = c;
         if (c == 35) check("hold_idle_busy", 64'(busy), 64'(0));
         if (c == 36) check("hold_rerun_busy", 64'(busy), 64'(1));
         if (c == 37) check("hold_rerun_index0", 64'({bus.out_valid, bus.out_index}), 64'({1'b1, 5'd0}));
      end
      check("hold_done_a", 64'(done_a), 64'(34));
      check("hold_done_b", 64'(done_b), 64'(69));
      check("hold_done_count", 64'(done_cnt - dcnt0), 64'(2));
      check("hold_final_busy", 64'(busy), 64'(0));
      check("hold_sb_empty",   64'(sb.size()), 64'(0));

      // Reset mid-dump while index 17 is on the bus.
      push_dump(18);
      dcnt0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1;
      for (int c = 1; c <= 19; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
      end
      check("mid_pre_index", 64'({bus.out_valid, bus.out_index}), 64'({1'b1, 5'd17}));
      #1 reset = 1'b1;
      #1;
      check("mid_rst_outputs",
            64'({busy, done, bus.out_valid, bus.out_last, bus.out_index, rf_raddr}), 64'(0));
      check("mid_rst_data", 64'(bus.out_data), 64'(0));
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      idle_cycles(5);
      check("mid_idle_busy",  64'(busy), 64'(0));
      check("mid_idle_valid", 64'(bus.out_valid), 64'(0));
      check("mid_no_done",    64'(done_cnt - dcnt0), 64'(0));
      check("mid_sb_empty",   64'(sb.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
